id_ex_buf: RTL
==============

# id_ex_buf

Pipeline register between the instruction-decode stage and the execute stage of the TinyRISC-V core. It captures the decoded bundle each cycle under a valid/ready handshake: instruction, address, operands, rd, branch offset and RAM request. It supports back-pressure from execute and a flush from branch/jump resolution. Whenever it holds nothing valid, it presents a canonical NOP bundle, so execute and RAM never act on stale data.

## Interface
- NOP_INST, 32'h0000_0013 — instruction presented when empty (addi x0,x0,0)
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flush_i  in  1  kill all held and incoming entries (taken branch/jump in execute)
- in_valid_i  in  1  decode bundle valid
- in_ready_o  out  1  buffer can accept a bundle this cycle
- inst_i, inst_addr_i  in  RV32_INST_WIDTH / RV32_ADDR_WIDTH  instruction and its PC
- op_data1_i, op_data2_i  in  DATA_WIDTH  operands
- rd_addr_i  in  REG_ADDR_WIDTH  destination register
- offset_addr_i  in  RV32_ADDR_WIDTH  B-type offset
- ram_rd_addr_i, ram_wr_addr_i  in  RV32_ADDR_WIDTH  RAM addresses
- ram_wr_data_i  in  DATA_WIDTH  RAM write data
- ram_wr_en_i  in  4  RAM byte write enables
- out_valid_o  out  1  bundle valid to execute
- out_ready_i  in  1  execute consumes bundle this cycle
- inst_o, inst_addr_o, op_data1_o, op_data2_o, rd_addr_o, offset_addr_o, ram_rd_addr_o, ram_wr_addr_o, ram_wr_data_o, ram_wr_en_o  out  widths as inputs  registered bundle

## Operation
- Transfer in: in_valid_i && in_ready_o. Transfer out: out_valid_o && out_ready_i.
- Order is strictly FIFO. No bundle is duplicated or dropped except by flush.
- Empty output bundle: inst_o=NOP_INST; all other data fields 0; ram_wr_en_o=4'b0000; out_valid_o=0.
- Flush:
  - All held entries are invalidated on the next edge.
  - A bundle offered in the flush cycle is discarded.
  - Flush has priority over every other event, including simultaneous input and output transfers.
- Reset: identical effect to flush. All outputs take the empty-bundle values.
- With skid (see Configuration), three states:
  - EMPTY: in_ready_o=1. Input transfer → FULL1.
  - FULL1 (main valid):
    - in and out transfer → FULL1 (main reloads);
    - out only → EMPTY;
    - in only → FULL2 (input parked in skid).
  - FULL2 (main+skid valid): in_ready_o=0.
    - Out transfer → FULL1, skid moves to main.
  - Any state + flush/rst → EMPTY.
- ram_wr_en_o is forced to 0 whenever out_valid_o=0, regardless of register contents.

## Timing
- Latency: a bundle accepted at edge N appears on the outputs after edge N (one cycle).
- Throughput is one bundle per cycle while out_ready_i=1.
- Skid build: in_ready_o is a pure register output (=!skid_valid), with no combinational path from out_ready_i.
- Non-skid build: in_ready_o = !out_valid_o || out_ready_i (combinational).
- All outputs are registered except the forced-zero gating of ram_wr_en_o and the NOP substitution. Both derive only from the valid flag.

## Configuration
- ID_EX_SKID_EN defined: two-entry skid buffer (main + skid) with registered in_ready_o, as described above.
- Undefined: single main register with no skid state.
  - States reduce to EMPTY/FULL1.
  - in_ready_o is combinational.
  - Flush and NOP rules are unchanged.

## Structure
- Shared defines: RV32_INST_WIDTH, RV32_ADDR_WIDTH, DATA_WIDTH, REG_ADDR_WIDTH, RST_DATA, RST_RAM_ADDR, RAM_WR_DISABLE, INST_NOP (32'h13), ID_EX_SKID_EN.
- The bundle is packed into one vector (BUNDLE_W = sum of field widths), with the width define in the shared file.
- One sub-module, pipe_reg_slot: a bundle-wide register with load enable and a valid bit that clears synchronously on clear. It is instantiated once for main and once for skid.

## Test plan
- Reset with garbage inputs and in_valid_i=1 → out_valid_o=0, inst_o=32'h13, ram_wr_en_o=0, in_ready_o=1 after the first edge.
- Stream 8 bundles (inst=0x00A00093+k) with out_ready_i=1 → identical sequence one cycle later, with no gaps.
- Hold out_ready_i=0 for 3 cycles while offering bundles A, B, C:
  - Skid: A and B are accepted, in_ready_o=0, C is held off.
  - On release: A, B, C emerge in order.
- An SW bundle (ram_wr_en=4'b1111) sits in main when flush_i=1 and new bundle D is offered → next cycle out_valid_o=0, ram_wr_en_o=0, D is never output.
- Flush asserted in FULL2 together with out_ready_i=1 → EMPTY next cycle; the skid entry is lost, and the next accepted bundle is output normally.
- Non-skid build, out_valid_o=1, out_ready_i toggles → in_ready_o follows out_ready_i in the same cycle.

Source files
------------

// File: rtl/id_ex_buf_pkg.sv
// Shared widths, reset values and bundle layout for the ID/EX pipeline register.
// ID_EX_SKID_EN selects the two-entry skid variant in id_ex_buf.
package id_ex_buf_pkg;

    localparam int unsigned RV32_INST_WIDTH = 32;
    localparam int unsigned RV32_ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned REG_ADDR_WIDTH  = 5;

    localparam logic [DATA_WIDTH-1:0]      RST_DATA       = '0;
    localparam logic [RV32_ADDR_WIDTH-1:0] RST_RAM_ADDR   = '0;
    localparam logic [3:0]                 RAM_WR_DISABLE = 4'b0000;
    localparam logic [RV32_INST_WIDTH-1:0] INST_NOP       = 32'h0000_0013;

    typedef struct packed {
        logic [RV32_INST_WIDTH-1:0] inst;
        logic [RV32_ADDR_WIDTH-1:0] inst_addr;
        logic [DATA_WIDTH-1:0]      op_data1;
        logic [DATA_WIDTH-1:0]      op_data2;
        logic [REG_ADDR_WIDTH-1:0]  rd_addr;
        logic [RV32_ADDR_WIDTH-1:0] offset_addr;
        logic [RV32_ADDR_WIDTH-1:0] ram_rd_addr;
        logic [RV32_ADDR_WIDTH-1:0] ram_wr_addr;
        logic [DATA_WIDTH-1:0]      ram_wr_data;
        logic [3:0]                 ram_wr_en;
    } bundle_t;

    localparam int unsigned BUNDLE_W = $bits(bundle_t);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL1 = 2'd1,
        FULL2 = 2'd2
    } state_t;

    function automatic bundle_t nop_bundle();
        bundle_t b;
        b             = '0;
        b.inst        = INST_NOP;
        b.inst_addr   = RST_RAM_ADDR;
        b.op_data1    = RST_DATA;
        b.op_data2    = RST_DATA;
        b.offset_addr = RST_RAM_ADDR;
        b.ram_rd_addr = RST_RAM_ADDR;
        b.ram_wr_addr = RST_RAM_ADDR;
        b.ram_wr_data = RST_DATA;
        b.ram_wr_en   = RAM_WR_DISABLE;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_buf_pipe_reg_slot.sv
// Bundle-wide register with load enable and a valid bit; clear wins over load and drop.
module pipe_reg_slot #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic         drop,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
        end else if (drop) begin
            valid <= 1'b0;
        end
        if (load && !clear) begin
            q <= d;
        end
    end

endmodule

// File: rtl/id_ex_buf.sv
// ID/EX pipeline register with valid/ready handshake, flush and NOP substitution when empty.
// `define ID_EX_SKID_EN for a main+skid pair with a registered in_ready_o.
module id_ex_buf
    import id_ex_buf_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [RV32_INST_WIDTH-1:0] inst_i,
    input  logic [RV32_ADDR_WIDTH-1:0] inst_addr_i,
    input  logic [DATA_WIDTH-1:0]      op_data1_i,
    input  logic [DATA_WIDTH-1:0]      op_data2_i,
    input  logic [REG_ADDR_WIDTH-1:0]  rd_addr_i,
    input  logic [RV32_ADDR_WIDTH-1:0] offset_addr_i,
    input  logic [RV32_ADDR_WIDTH-1:0] ram_rd_addr_i,
    input  logic [RV32_ADDR_WIDTH-1:0] ram_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]      ram_wr_data_i,
    input  logic [3:0]                 ram_wr_en_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [RV32_INST_WIDTH-1:0] inst_o,
    output logic [RV32_ADDR_WIDTH-1:0] inst_addr_o,
    output logic [DATA_WIDTH-1:0]      op_data1_o,
    output logic [DATA_WIDTH-1:0]      op_data2_o,
    output logic [REG_ADDR_WIDTH-1:0]  rd_addr_o,
    output logic [RV32_ADDR_WIDTH-1:0] offset_addr_o,
    output logic [RV32_ADDR_WIDTH-1:0] ram_rd_addr_o,
    output logic [RV32_ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]      ram_wr_data_o,
    output logic [3:0]                 ram_wr_en_o
);

    bundle_t in_b;
    bundle_t main_d;
    bundle_t main_q;
    bundle_t out_b;
    logic    clear;
    logic    main_valid;
    logic    main_load;
    logic    main_drop;
    logic    in_xfer;
    logic    out_xfer;
    state_t  state;

    assign in_b.inst        = inst_i;
    assign in_b.inst_addr   = inst_addr_i;
    assign in_b.op_data1    = op_data1_i;
    assign in_b.op_data2    = op_data2_i;
    assign in_b.rd_addr     = rd_addr_i;
    assign in_b.offset_addr = offset_addr_i;
    assign in_b.ram_rd_addr = ram_rd_addr_i;
    assign in_b.ram_wr_addr = ram_wr_addr_i;
    assign in_b.ram_wr_data = ram_wr_data_i;
    assign in_b.ram_wr_en   = ram_wr_en_i;

    assign clear    = rst | flush_i;
    assign in_xfer  = in_valid_i & in_ready_o;
    assign out_xfer = main_valid & out_ready_i;

`ifdef ID_EX_SKID_EN
    bundle_t skid_q;
    logic    skid_valid;
    logic    skid_load;
    logic    skid_drop;
    logic    main_from_skid;

    // in_ready_o comes straight from the skid valid flop, cutting the out_ready_i path.
    assign in_ready_o = !skid_valid;
    assign state      = skid_valid ? FULL2 : (main_valid ? FULL1 : EMPTY);
    assign main_d     = main_from_skid ? skid_q : in_b;

    always_comb begin
        main_load      = 1'b0;
        main_drop      = 1'b0;
        skid_load      = 1'b0;
        skid_drop      = 1'b0;
        main_from_skid = 1'b0;
        case (state)
            EMPTY: main_load = in_xfer;
            FULL1: begin
                if (in_xfer && out_xfer) begin
                    main_load = 1'b1;
                end else if (out_xfer) begin
                    main_drop = 1'b1;
                end else if (in_xfer) begin
                    skid_load = 1'b1;
                end
            end
            FULL2: begin
                if (out_xfer) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    skid_drop      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    pipe_reg_slot #(.W(BUNDLE_W)) u_skid (
        .clk   (clk),
        .clear (clear),
        .load  (skid_load),
        .drop  (skid_drop),
        .d     (in_b),
        .valid (skid_valid),
        .q     (skid_q)
    );
`else
    assign in_ready_o = !main_valid || out_ready_i;
    assign state      = main_valid ? FULL1 : EMPTY;
    assign main_d     = in_b;

    always_comb begin
        main_load = 1'b0;
        main_drop = 1'b0;
        case (state)
            EMPTY: main_load = in_xfer;
            FULL1: begin
                if (in_xfer) begin
                    main_load = 1'b1;
                end else if (out_xfer) begin
                    main_drop = 1'b1;
                end
            end
            default: ;
        endcase
    end
`endif

    pipe_reg_slot #(.W(BUNDLE_W)) u_main (
        .clk   (clk),
        .clear (clear),
        .load  (main_load),
        .drop  (main_drop),
        .d     (main_d),
        .valid (main_valid),
        .q     (main_q)
    );

    // Empty slot shows the NOP bundle, which also forces ram_wr_en_o to zero.
    assign out_b = main_valid ? main_q : nop_bundle();

    assign out_valid_o   = main_valid;
    assign inst_o        = out_b.inst;
    assign inst_addr_o   = out_b.inst_addr;
    assign op_data1_o    = out_b.op_data1;
    assign op_data2_o    = out_b.op_data2;
    assign rd_addr_o     = out_b.rd_addr;
    assign offset_addr_o = out_b.offset_addr;
    assign ram_rd_addr_o = out_b.ram_rd_addr;
    assign ram_wr_addr_o = out_b.ram_wr_addr;
    assign ram_wr_data_o = out_b.ram_wr_data;
    assign ram_wr_en_o   = out_b.ram_wr_en;

endmodule
